one_to_sixteen_deserializer_fsm: RTL and testbench



---
 rtl/one_to_sixteen_deserializer_fsm_if.sv | 36 +++
 rtl/one_to_sixteen_deserializer_fsm.sv | 131 +++++++++++++
 tb/tb_one_to_sixteen_deserializer_fsm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/one_to_sixteen_deserializer_fsm_if.sv
// Serial-in / parallel-out bundle for the 1-to-16 deserializer; slave is the deserializer.
// DESER_PARITY_EN adds the parity_error pulse to the bundle.
interface one_to_sixteen_deserializer_fsm_if #(
    parameter int WIDTH = 16
);
    logic             data_input;
    logic             ss;
    logic             data_ack;
    logic [WIDTH-1:0] data_output;
    logic             data_valid;
    logic             overrun;
    logic             frame_error;
    logic             busy;
    logic [1:0]       y_Q;
`ifdef DESER_PARITY_EN
    logic             parity_error;

    modport master (
        output data_input, ss, data_ack,
        input  data_output, data_valid, overrun, frame_error, busy, y_Q, parity_error
    );
    modport slave (
        input  data_input, ss, data_ack,
        output data_output, data_valid, overrun, frame_error, busy, y_Q, parity_error
    );
`else
    modport master (
        output data_input, ss, data_ack,
        input  data_output, data_valid, overrun, frame_error, busy, y_Q
    );
    modport slave (
        input  data_input, ss, data_ack,
        output data_output, data_valid, overrun, frame_error, busy, y_Q
    );
`endif
endinterface

// File: rtl/one_to_sixteen_deserializer_fsm.sv
// ss-framed MSB-first deserializer; DESER_PARITY_EN appends an even-parity bit to each frame.
// Word is valid on the edge sampling its last bit; no backpressure, an unacked word is overwritten and flags overrun.
module one_to_sixteen_deserializer_fsm #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic clock,
    input logic resetn,
    one_to_sixteen_deserializer_fsm_if.slave bus
);
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam int CW    = CNT_W + 1;
    localparam int SW    = WIDTH;
`else
    localparam int FRAME = WIDTH;
    localparam int CW    = CNT_W;
    localparam int SW    = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_END  = 2'b10
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    shift_q;
    logic [WIDTH-1:0] data_output_q;
    logic             data_valid_q;
    logic             overrun_q;
    logic             frame_error_q;
    logic [WIDTH-1:0] word_c;
    logic             par_ok_c;
    logic             last_c;
    logic             load_c;
    logic             bad_par_c;

    // The shifter holds every bit except the one being sampled on the final edge.
    always_comb begin
`ifdef DESER_PARITY_EN
        word_c   = shift_q;
        par_ok_c = ~(^shift_q ^ bus.data_input);
`else
        word_c   = {shift_q, bus.data_input};
        par_ok_c = 1'b1;
`endif
        last_c    = (state_q == ST_RECV) && !bus.ss && (cnt_q == CW'(FRAME - 1));
        load_c    = last_c && par_ok_c;
        bad_par_c = last_c && !par_ok_c;
    end

`ifdef DESER_PARITY_EN
    logic parity_error_q;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            data_output_q  <= '0;
            data_valid_q   <= 1'b0;
            overrun_q      <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            frame_error_q  <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_error_q <= bad_par_c;
`endif
            // A completing word takes priority over an ack on the same edge.
            if (load_c) begin
                data_output_q <= word_c;
                data_valid_q  <= 1'b1;
                if (data_valid_q && !bus.data_ack)
                    overrun_q <= 1'b1;
            end else if (bus.data_ack) begin
                data_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!bus.ss) begin
                        shift_q <= {{(SW-1){1'b0}}, bus.data_input};
                        cnt_q   <= CW'(1);
                        state_q <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (bus.ss) begin
                        shift_q       <= '0;
                        cnt_q         <= '0;
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (last_c) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_END;
                    end else begin
                        shift_q <= {shift_q[SW-2:0], bus.data_input};
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                ST_END: begin
                    if (bus.ss)
                        state_q <= ST_IDLE;
                end
                default: begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_output = data_output_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_error = frame_error_q;
    assign bus.y_Q         = state_q;
    assign bus.busy        = (state_q == ST_RECV);
`ifdef DESER_PARITY_EN
    assign bus.parity_error = parity_error_q;
`endif
endmodule

// File: tb/tb_one_to_sixteen_deserializer_fsm.sv
// Bench for one_to_sixteen_deserializer_fsm: frame table, directed corner sequences, then random traffic
// against a bit-list reference model. Define DESER_PARITY_EN to exercise the parity build.
module tb_one_to_sixteen_deserializer_fsm;
    localparam int WIDTH = 16;
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clock = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    one_to_sixteen_deserializer_fsm_if #(.WIDTH(WIDTH)) bus ();

    one_to_sixteen_deserializer_fsm #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference model: bits collected so far in the open frame, and whether a frame already completed under this ss-low.
    int unsigned m_bits;
    int          m_n;
    bit          m_done;
    logic [15:0] m_dout;
    bit          m_valid, m_ovr, m_fe, m_pe;

    task automatic model_step(input logic rn, input logic s, input logic d, input logic a);
        bit          load;
        int unsigned word;
        load = 0;
        word = 0;
        if (!rn) begin
            m_bits = 0; m_n = 0; m_done = 0; m_dout = '0;
            m_valid = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
        end else begin
            m_fe = 0;
            m_pe = 0;
            if (!s) begin
                if (!m_done) begin
                    m_bits = m_bits * 2 + (d ? 1 : 0);
                    m_n++;
                    if (m_n == FRAME) begin
`ifdef DESER_PARITY_EN
                        word = m_bits >> 1;
                        if (($countones(word) % 2) == (m_bits % 2)) load = 1;
                        else m_pe = 1;
`else
                        word = m_bits;
                        load = 1;
`endif
                        m_done = 1;
                        m_n    = 0;
                        m_bits = 0;
                    end
                end
            end else begin
                if (m_n > 0) m_fe = 1;
                m_n = 0; m_bits = 0; m_done = 0;
            end
            if (load) begin
                if (m_valid && !a) m_ovr = 1;
                m_dout  = word[15:0];
                m_valid = 1;
            end else if (a) begin
                m_valid = 0;
                m_ovr   = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [1:0] st;
        st = (m_n > 0) ? 2'd1 : (m_done ? 2'd2 : 2'd0);
        return {9'b0, m_dout, m_valid, m_ovr, m_fe, (m_n > 0), st, m_pe};
    endfunction

    function automatic logic [31:0] dut_vec();
        logic pe;
`ifdef DESER_PARITY_EN
        pe = bus.parity_error;
`else
        pe = 1'b0;
`endif
        return {9'b0, bus.data_output, bus.data_valid, bus.overrun, bus.frame_error,
                bus.busy, bus.y_Q, pe};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic s, input logic d, input logic a);
        resetn = rn; bus.ss = s; bus.data_input = d; bus.data_ack = a;
        @(posedge clock);
        model_step(rn, s, d, a);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] word, input logic ack_last, input logic bad_par);
        logic [16:0] fb;
`ifdef DESER_PARITY_EN
        fb = {word, (^word) ^ bad_par};
`else
        fb = {1'b0, word};
        if (bad_par) fb = {1'b0, word};
`endif
        for (int i = FRAME - 1; i >= 0; i--)
            drive(1'b1, 1'b0, fb[i], (i == 0) ? ack_last : 1'b0);
    endtask

    typedef struct {
        logic [15:0] word;
        logic        ack_last;
        logic        ack_after;
        logic [15:0] exp_dout;
        logic        exp_valid;
        logic        exp_ovr;
        logic        exp_valid_after;
        logic        exp_ovr_after;
    } frame_vec_t;

    frame_vec_t tbl[6];

    initial begin
        tbl[0] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h5678, 1'b1, 1'b0, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'h0F0F, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b0, 1'b0};

        resetn = 1'b0; bus.ss = 1'b1; bus.data_input = 1'b0; bus.data_ack = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_all", dut_vec(), 32'h0);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].word, tbl[i].ack_last, 1'b0);
            check($sformatf("row%0d_dout", i), 32'(bus.data_output), 32'(tbl[i].exp_dout));
            check($sformatf("row%0d_valid", i), 32'(bus.data_valid), 32'(tbl[i].exp_valid));
            check($sformatf("row%0d_ovr", i), 32'(bus.overrun), 32'(tbl[i].exp_ovr));
            check($sformatf("row%0d_state", i), 32'(bus.y_Q), 32'd2);
            check($sformatf("row%0d_busy", i), 32'(bus.busy), 32'd0);
            drive(1'b1, 1'b1, 1'b0, tbl[i].ack_after);
            check($sformatf("row%0d_valid_after", i), 32'(bus.data_valid), 32'(tbl[i].exp_valid_after));
            check($sformatf("row%0d_ovr_after", i), 32'(bus.overrun), 32'(tbl[i].exp_ovr_after));
            check($sformatf("row%0d_idle", i), 32'(bus.y_Q), 32'd0);
        end

        // Abort after 7 bits.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'(i & 1), 1'b0);
        check("abort_busy", 32'(bus.busy), 32'd1);
        check("abort_recv", 32'(bus.y_Q), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_fe", 32'(bus.frame_error), 32'd1);
        check("abort_idle", 32'(bus.y_Q), 32'd0);
        check("abort_dout", 32'(bus.data_output), 32'h0F0F);
        check("abort_valid", 32'(bus.data_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_fe_pulse", 32'(bus.frame_error), 32'd0);
        send_frame(16'h00FF, 1'b0, 1'b0);
        check("after_abort_dout", 32'(bus.data_output), 32'h00FF);
        check("after_abort_valid", 32'(bus.data_valid), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset during bit 10.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("midreset_all", dut_vec(), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("midreset_no_fe", dut_vec(), 32'h0);

        // ss held low well past the end of a frame.
        send_frame(16'h3C3C, 1'b0, 1'b0);
        check("long_ss_valid", 32'(bus.data_valid), 32'd1);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1'($urandom), (k == 0));
        check("long_ss_dout", 32'(bus.data_output), 32'h3C3C);
        check("long_ss_valid_after", 32'(bus.data_valid), 32'd0);
        check("long_ss_state", 32'(bus.y_Q), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("long_ss_idle", 32'(bus.y_Q), 32'd0);

`ifdef DESER_PARITY_EN
        send_frame(16'h8001, 1'b0, 1'b0);
        check("par_good_dout", 32'(bus.data_output), 32'h8001);
        check("par_good_valid", 32'(bus.data_valid), 32'd1);
        check("par_good_pe", 32'(bus.parity_error), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(16'h8001, 1'b0, 1'b1);
        check("par_bad_pe", 32'(bus.parity_error), 32'd1);
        check("par_bad_valid", 32'(bus.data_valid), 32'd0);
        check("par_bad_state", 32'(bus.y_Q), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("par_bad_pe_pulse", 32'(bus.parity_error), 32'd0);
`endif

        // Random traffic against the model.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) == 0),
                  1'($urandom), ($urandom_range(0, 4) == 0));
            check($sformatf("rand_cycle%0d", c), dut_vec(), model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
